// File: rtl/axis_hdr_field_tap.sv
// ---------------------------------------------------------------------------
// axis_hdr_field_tap : AXI4-Stream pass-through FIFO that taps one header field
// per packet on the master side, flags short packets and counts packets. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axis_hdr_field_tap #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH_BITS    = 2,
  parameter int FIELD_BEAT         = 1,
  parameter int FIELD_LSB          = 240,
  parameter int FIELD_WIDTH        = 16,
  parameter int BEAT_CNT_WIDTH     = 8
) (
  input  logic                            AXI_ACLK,
  input  logic                            AXI_RESET,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                            S_AXIS_TVALID,
  output logic                            S_AXIS_TREADY,
  input  logic                            S_AXIS_TLAST,
  output logic [C_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic                            M_AXIS_TLAST,
  output logic [FIELD_WIDTH-1:0]          field_data,
  output logic                            field_valid,
  output logic                            field_miss,
  output logic [31:0]                     pkt_count
);

  localparam int STRB_W  = C_AXIS_DATA_WIDTH / 8;
  localparam int ENTRY_W = 1 + C_AXIS_TUSER_WIDTH + STRB_W + C_AXIS_DATA_WIDTH;
  localparam int DEPTH   = 2 ** FIFO_DEPTH_BITS;
  localparam int PTR_W   = FIFO_DEPTH_BITS + 1;

  localparam logic [PTR_W-1:0]          C_PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]          C_DEPTH     = PTR_W'(DEPTH);
  localparam logic [BEAT_CNT_WIDTH-1:0] C_BEAT_ONE  = BEAT_CNT_WIDTH'(1);
  localparam logic [BEAT_CNT_WIDTH-1:0] C_BEAT_MAX  = '1;
  localparam logic [BEAT_CNT_WIDTH-1:0] C_FIELD_BEAT = BEAT_CNT_WIDTH'(FIELD_BEAT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } state_e;

  logic [ENTRY_W-1:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W-1:0]          occupancy;
  logic                      full, empty, wr_en, ohs;
  logic [ENTRY_W-1:0]        head;

  state_e                    state_q, state_d;
  logic [BEAT_CNT_WIDTH-1:0] beat_q, beat_d;
  logic [FIELD_WIDTH-1:0]    field_q, field_d;
  logic                      fvalid_q, fvalid_d;
  logic                      fmiss_q, fmiss_d;
  logic [31:0]               pkt_q, pkt_d;
  logic                      capture, miss;

  // Ready depends only on occupancy, so a full FIFO refuses even when draining.
  assign occupancy     = wptr_q - rptr_q;
  assign full          = (occupancy == C_DEPTH);
  assign empty         = (wptr_q == rptr_q);
  assign S_AXIS_TREADY = !full && !AXI_RESET;
  assign M_AXIS_TVALID = !empty;
  assign wr_en         = S_AXIS_TVALID && S_AXIS_TREADY;
  assign ohs           = M_AXIS_TVALID && M_AXIS_TREADY;

  assign head = mem_q[rptr_q[FIFO_DEPTH_BITS-1:0]];
  assign {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TDATA} = head;

  always_ff @(posedge AXI_ACLK) begin
    if (wr_en) begin
      mem_q[wptr_q[FIFO_DEPTH_BITS-1:0]] <=
        {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
    end
  end

  assign wptr_d = wr_en ? (wptr_q + C_PTR_ONE) : wptr_q;
  assign rptr_d = ohs   ? (rptr_q + C_PTR_ONE) : rptr_q;

  assign capture = ohs && (beat_q == C_FIELD_BEAT);
  assign miss    = ohs && M_AXIS_TLAST && (beat_q < C_FIELD_BEAT);

  always_comb begin
    beat_d   = beat_q;
    field_d  = field_q;
    fvalid_d = capture;
    fmiss_d  = miss;
    pkt_d    = pkt_q;
    if (ohs) begin
      if (M_AXIS_TLAST) begin
        beat_d = '0;
        pkt_d  = pkt_q + 32'd1;
      end else if (beat_q != C_BEAT_MAX) begin
        beat_d = beat_q + C_BEAT_ONE;
      end
    end
    if (capture) begin
      field_d = M_AXIS_TDATA[FIELD_LSB +: FIELD_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ohs && !M_AXIS_TLAST) begin
          state_d = (FIELD_BEAT == 0) ? ST_BODY : ST_HDR;
        end
      end
      ST_HDR: begin
        if (ohs) begin
          if (M_AXIS_TLAST) begin
            state_d = ST_IDLE;
          end else if (beat_q == C_FIELD_BEAT) begin
            state_d = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (ohs && M_AXIS_TLAST) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      field_q  <= '0;
      fvalid_q <= 1'b0;
      fmiss_q  <= 1'b0;
      pkt_q    <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      state_q  <= state_d;
      beat_q   <= beat_d;
      field_q  <= field_d;
      fvalid_q <= fvalid_d;
      fmiss_q  <= fmiss_d;
      pkt_q    <= pkt_d;
    end
  end

  assign field_data  = field_q;
  assign field_valid = fvalid_q;
  assign field_miss  = fmiss_q;
  assign pkt_count   = pkt_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_hdr_field_tap.sv
// ---------------------------------------------------------------------------
// tb_axis_hdr_field_tap : directed bench for axis_hdr_field_tap. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axis_hdr_field_tap;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int SW = DW / 8;
  localparam int EW = 1 + UW + SW + DW;

  logic          clk = 1'b0;
  logic          AXI_RESET;
  logic [DW-1:0] S_AXIS_TDATA;
  logic [SW-1:0] S_AXIS_TSTRB;
  logic [UW-1:0] S_AXIS_TUSER;
  logic          S_AXIS_TVALID;
  logic          S_AXIS_TREADY;
  logic          S_AXIS_TLAST;
  logic [DW-1:0] M_AXIS_TDATA;
  logic [SW-1:0] M_AXIS_TSTRB;
  logic [UW-1:0] M_AXIS_TUSER;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TREADY;
  logic          M_AXIS_TLAST;
  logic [15:0]   field_data;
  logic          field_valid;
  logic          field_miss;
  logic [31:0]   pkt_count;

  always #5 clk = ~clk;

  axis_hdr_field_tap dut (
    .AXI_ACLK      (clk),
    .AXI_RESET     (AXI_RESET),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TSTRB  (S_AXIS_TSTRB),
    .S_AXIS_TUSER  (S_AXIS_TUSER),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TSTRB  (M_AXIS_TSTRB),
    .M_AXIS_TUSER  (M_AXIS_TUSER),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .field_data    (field_data),
    .field_valid   (field_valid),
    .field_miss    (field_miss),
    .pkt_count     (pkt_count)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int exp_pkts = 0;
  bit rand_rdy = 1'b0;

  logic [EW-1:0] outq[$];
  int            ohs_cyc[$];
  logic [15:0]   fq[$];
  int            fv_cyc[$];
  int            miss_n = 0;
  int            both_n = 0;

  always @(posedge clk) cyc++;

  // Monitor samples on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (M_AXIS_TVALID && M_AXIS_TREADY) begin
      outq.push_back({M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TDATA});
      ohs_cyc.push_back(cyc);
    end
    if (field_valid) begin
      fq.push_back(field_data);
      fv_cyc.push_back(cyc);
    end
    if (field_miss) miss_n++;
    if (field_valid && field_miss) both_n++;
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      M_AXIS_TREADY = 1'($urandom_range(0, 1));
    end
  end

  function automatic logic [DW-1:0] mk(input logic [15:0] fld, input logic [15:0] pk,
                                       input logic [15:0] bt);
    return {fld, pk, bt, {13{16'hBEEF}}};
  endfunction

  function automatic logic [EW-1:0] ent(input logic [DW-1:0] d, input logic last);
    return {last, {4{d[255:224]}}, d[31:0], d};
  endfunction

  task automatic clear_mon();
    outq.delete(); ohs_cyc.delete(); fq.delete(); fv_cyc.delete();
    miss_n = 0; both_n = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send_beat(input logic [DW-1:0] d, input logic last, input int gap,
                           output bit ok);
    repeat (gap) begin @(posedge clk); #1; end
    S_AXIS_TDATA  = d;
    S_AXIS_TSTRB  = d[31:0];
    S_AXIS_TUSER  = {4{d[255:224]}};
    S_AXIS_TLAST  = last;
    S_AXIS_TVALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (S_AXIS_TREADY) ok = 1'b1;
      @(posedge clk); #1;
    end
    S_AXIS_TVALID = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    for (int i = 0; i < 400 && outq.size() < n; i++) @(posedge clk);
    repeat (3) @(negedge clk);
    nvec++;
    if (outq.size() != n) begin
      nerr++;
      $display("FAIL drain_count: got %0d beats want %0d", outq.size(), n);
    end
  endtask

  task automatic test_reset();
    AXI_RESET = 1'b1; S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0; M_AXIS_TREADY = 1'b0;
    S_AXIS_TDATA = '0; S_AXIS_TSTRB = '0; S_AXIS_TUSER = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nvec++;
    if (S_AXIS_TREADY !== 1'b0 || M_AXIS_TVALID !== 1'b0) begin
      nerr++;
      $display("FAIL reset_ready_valid: got tready=%b tvalid=%b want 0 0", S_AXIS_TREADY, M_AXIS_TVALID);
    end
    nvec++;
    if ({field_valid, field_miss, field_data, pkt_count} !== 50'd0) begin
      nerr++;
      $display("FAIL reset_outputs: got fv=%b fm=%b fd=%h pc=%h want all 0",
               field_valid, field_miss, field_data, pkt_count);
    end
    AXI_RESET = 1'b0;
    @(posedge clk); #1;
    nvec++;
    if (S_AXIS_TREADY !== 1'b1 || M_AXIS_TVALID !== 1'b0) begin
      nerr++;
      $display("FAIL release_ready: got tready=%b tvalid=%b want 1 0", S_AXIS_TREADY, M_AXIS_TVALID);
    end
  endtask

  task automatic test_basic_capture();
    logic [DW-1:0] d[3];
    bit ok;
    d[0] = mk(16'h1234, 16'd1, 16'd0);
    d[1] = mk(16'hC0A8, 16'd1, 16'd1);
    d[2] = mk(16'h5678, 16'd1, 16'd2);
    @(posedge clk); #1;
    M_AXIS_TREADY = 1'b1;
    clear_mon();
    for (int i = 0; i < 3; i++) send_beat(d[i], 1'(i == 2), 0, ok);
    exp_pkts++;
    wait_drain(3);
    for (int i = 0; i < 3 && i < outq.size(); i++) begin
      nvec++;
      if (outq[i] !== ent(d[i], 1'(i == 2))) begin
        nerr++;
        $display("FAIL basic_beat%0d: got %h want %h", i, outq[i], ent(d[i], 1'(i == 2)));
      end
    end
    nvec++;
    if (fq.size() != 1 || field_data !== 16'hC0A8) begin
      nerr++;
      $display("FAIL basic_field: got %0d pulses fd=%h want 1 pulse fd=c0a8", fq.size(), field_data);
    end
    nvec++;
    if (fv_cyc.size() != 1 || ohs_cyc.size() < 2 || fv_cyc[0] != ohs_cyc[1] + 1) begin
      nerr++;
      $display("FAIL basic_pulse_timing: got %0d pulses, first at %0d want one pulse at beat1+1",
               fv_cyc.size(), (fv_cyc.size() > 0) ? fv_cyc[0] : -1);
    end
    nvec++;
    if (pkt_count !== 32'(exp_pkts) || miss_n != 0) begin
      nerr++;
      $display("FAIL basic_count: got pc=%0d miss=%0d want pc=%0d miss=0", pkt_count, miss_n, exp_pkts);
    end
  endtask

  task automatic test_short_pkt();
    bit ok;
    @(posedge clk); #1;
    clear_mon();
    send_beat(mk(16'h7777, 16'd2, 16'd0), 1'b1, 0, ok);
    exp_pkts++;
    wait_drain(1);
    nvec++;
    if (miss_n != 1 || fq.size() != 0) begin
      nerr++;
      $display("FAIL short_miss: got miss=%0d fv=%0d want miss=1 fv=0", miss_n, fq.size());
    end
    nvec++;
    if (field_data !== 16'hC0A8 || pkt_count !== 32'(exp_pkts)) begin
      nerr++;
      $display("FAIL short_hold: got fd=%h pc=%0d want fd=c0a8 pc=%0d", field_data, pkt_count, exp_pkts);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d[6];
    bit ok;
    int acc;
    for (int i = 0; i < 6; i++) d[i] = mk((i == 1) ? 16'h3333 : 16'h4400 + 16'(i), 16'd3, 16'(i));
    @(posedge clk); #1;
    M_AXIS_TREADY = 1'b0;
    clear_mon();
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      send_beat(d[i], 1'b0, 0, ok);
      if (ok) acc++;
    end
    nvec++;
    if (acc != 4) begin
      nerr++;
      $display("FAIL bp_accept4: got %0d accepted want 4", acc);
    end
    S_AXIS_TDATA = d[4]; S_AXIS_TSTRB = d[4][31:0]; S_AXIS_TUSER = {4{d[4][255:224]}};
    S_AXIS_TLAST = 1'b0; S_AXIS_TVALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      nvec++;
      if (S_AXIS_TREADY !== 1'b0 || M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== d[0]) begin
        nerr++;
        $display("FAIL bp_full_stable: got tready=%b tvalid=%b tdata=%h want 0 1 %h",
                 S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, d[0]);
      end
    end
    @(posedge clk); #1;
    M_AXIS_TREADY = 1'b1;
    send_beat(d[4], 1'b0, 0, ok);
    send_beat(d[5], 1'b1, 0, ok);
    exp_pkts++;
    wait_drain(6);
    for (int i = 0; i < 6 && i < outq.size(); i++) begin
      nvec++;
      if (outq[i] !== ent(d[i], 1'(i == 5))) begin
        nerr++;
        $display("FAIL bp_beat%0d: got %h want %h", i, outq[i], ent(d[i], 1'(i == 5)));
      end
    end
    nvec++;
    if (field_data !== 16'h3333 || fq.size() != 1) begin
      nerr++;
      $display("FAIL bp_field: got fd=%h pulses=%0d want 3333 1", field_data, fq.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d[4];
    bit ok;
    d[0] = mk(16'hDEAD, 16'd4, 16'd0);
    d[1] = mk(16'h1111, 16'd4, 16'd1);
    d[2] = mk(16'h0BAD, 16'd5, 16'd0);
    d[3] = mk(16'h2222, 16'd5, 16'd1);
    @(posedge clk); #1;
    clear_mon();
    rand_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(d[i], 1'(i % 2), $urandom_range(0, 1), ok);
    exp_pkts += 2;
    for (int i = 0; i < 400 && outq.size() < 4; i++) @(posedge clk);
    rand_rdy = 1'b0;
    @(negedge clk);
    M_AXIS_TREADY = 1'b1;
    wait_drain(4);
    for (int i = 0; i < 4 && i < outq.size(); i++) begin
      nvec++;
      if (outq[i] !== ent(d[i], 1'(i % 2))) begin
        nerr++;
        $display("FAIL b2b_beat%0d: got %h want %h", i, outq[i], ent(d[i], 1'(i % 2)));
      end
    end
    nvec++;
    if (fq.size() != 2 || fq[0] !== 16'h1111 || fq[1] !== 16'h2222) begin
      nerr++;
      $display("FAIL b2b_fields: got %0d pulses first=%h want 2 pulses 1111 2222",
               fq.size(), (fq.size() > 0) ? fq[0] : 16'hxxxx);
    end
    nvec++;
    if (pkt_count !== 32'(exp_pkts) || both_n != 0 || miss_n != 0) begin
      nerr++;
      $display("FAIL b2b_count: got pc=%0d both=%0d miss=%0d want pc=%0d 0 0",
               pkt_count, both_n, miss_n, exp_pkts);
    end
  endtask

  task automatic test_reset_midpkt();
    logic [DW-1:0] d[4];
    bit ok;
    for (int i = 0; i < 4; i++) d[i] = mk((i == 1) ? 16'hABCD : 16'h6600 + 16'(i), 16'd6, 16'(i));
    @(posedge clk); #1;
    M_AXIS_TREADY = 1'b0;
    send_beat(d[0], 1'b0, 0, ok);
    AXI_RESET = 1'b1;
    #1;
    nvec++;
    if (M_AXIS_TVALID !== 1'b0 || S_AXIS_TREADY !== 1'b0) begin
      nerr++;
      $display("FAIL rst_mid_handshake: got tvalid=%b tready=%b want 0 0", M_AXIS_TVALID, S_AXIS_TREADY);
    end
    nvec++;
    if ({field_valid, field_miss, field_data, pkt_count} !== 50'd0) begin
      nerr++;
      $display("FAIL rst_mid_outputs: got fd=%h pc=%0d want 0 0", field_data, pkt_count);
    end
    exp_pkts = 0;
    @(negedge clk);
    AXI_RESET = 1'b0;
    @(posedge clk); #1;
    M_AXIS_TREADY = 1'b1;
    clear_mon();
    for (int i = 0; i < 4; i++) send_beat(d[i], 1'(i == 3), 0, ok);
    exp_pkts++;
    wait_drain(4);
    nvec++;
    if (fq.size() != 1 || field_data !== 16'hABCD || pkt_count !== 32'(exp_pkts)) begin
      nerr++;
      $display("FAIL rst_mid_next: got pulses=%0d fd=%h pc=%0d want 1 abcd %0d",
               fq.size(), field_data, pkt_count, exp_pkts);
    end
  endtask

  task automatic test_count_wrap();
    bit ok;
    @(posedge clk); #1;
    force dut.pkt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.pkt_q;
    clear_mon();
    send_beat(mk(16'h9999, 16'd7, 16'd0), 1'b1, 0, ok);
    wait_drain(1);
    nvec++;
    if (pkt_count !== 32'd0) begin
      nerr++;
      $display("FAIL count_wrap: got %h want 00000000", pkt_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_short_pkt();
    test_backpressure();
    test_back_to_back();
    test_reset_midpkt();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
